display_mux: RTL and testbench

- Time-multiplexes the two 4-bit switch values onto a shared seven-segment bus with two digit enables.
- Sits beside the LED sum logic.
- Takes the same switch1/switch2 inputs as the sum logic, synchronizes them and hex-decodes them. Drives one digit at a time, with a blanking gap between digits to prevent ghosting.

---
 rtl/display_mux.sv | 62 ++++++
 tb/tb_display_mux.sv | 125 ++++++++++++
 2 files changed

// File: rtl/display_mux.sv
// display_mux: time-multiplexes two synchronized hex switch values onto a shared
// seven-segment bus, with a blanking gap between digits to prevent ghosting.
module display_mux #(
   parameter int REFRESH_CYCLES = 24000,
   parameter int BLANK_CYCLES   = 240
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] switch1,
   input  logic [3:0] switch2,
   output logic [6:0] seg_n,
   output logic [1:0] anode_n,
   output logic       frame_start
);
   localparam int MAXN = REFRESH_CYCLES > BLANK_CYCLES ? REFRESH_CYCLES : BLANK_CYCLES;
   localparam int CW = $clog2(MAXN);
   localparam logic [6:0] HEX [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };
   typedef enum logic [1:0] {BLANK_L, SHOW_L, BLANK_R, SHOW_R} state_t;
   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [3:0]      sw1_s1, sw1_s2, sw2_s1, sw2_s2;
   logic            last;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state  <= BLANK_L;
         cnt    <= '0;
         sw1_s1 <= '0;
         sw1_s2 <= '0;
         sw2_s1 <= '0;
         sw2_s2 <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         sw1_s1 <= switch1;
         sw1_s2 <= sw1_s1;
         sw2_s1 <= switch2;
         sw2_s2 <= sw2_s1;
      end
   always_comb begin
      last      = cnt == ((state == SHOW_L || state == SHOW_R) ? CW'(REFRESH_CYCLES - 1) : CW'(BLANK_CYCLES - 1));
      state_nxt = last ? state_t'(state + 2'd1) : state;
      cnt_nxt   = last ? '0 : cnt + CW'(1);
   end
   // segments are captured only on state entry, so each SHOW phase stays frozen
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         seg_n       <= 7'h7F;
         anode_n     <= 2'b11;
         frame_start <= 1'b0;
      end else begin
         frame_start <= last && state == BLANK_L;
         if (last) begin
            anode_n <= state_nxt == SHOW_L ? 2'b01 : state_nxt == SHOW_R ? 2'b10 : 2'b11;
            seg_n   <= state_nxt == SHOW_L ? HEX[sw1_s2] : state_nxt == SHOW_R ? HEX[sw2_s2] : 7'h7F;
         end
      end
endmodule

// File: tb/tb_display_mux.sv
// tb_display_mux: directed checks of frame timing, decode, freeze and async reset.
module tb_display_mux;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] switch1 = 4'h0;
   logic [3:0] switch2 = 4'h0;
   logic [6:0] seg_n;
   logic [1:0] anode_n;
   logic       frame_start;
   int checks = 0;
   int failures = 0;
   localparam logic [6:0] D [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };
   display_mux #(.REFRESH_CYCLES(8), .BLANK_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .switch1(switch1), .switch2(switch2),
      .seg_n(seg_n), .anode_n(anode_n), .frame_start(frame_start)
   );
   always #5 clk = ~clk;
   task automatic check_blank(input string tag);
      checks++;
      assert ({anode_n, seg_n, frame_start} === {2'b11, 7'h7F, 1'b0}) else begin
         failures++;
         $error("FAIL %s got an=%b seg=%b fs=%b exp an=11 seg=1111111 fs=0", tag, anode_n, seg_n, frame_start);
      end
   endtask
   // frame index k: 0-1 blank, 2-9 left (pulse at 2), 10-11 blank, 12-19 right
   task automatic frame(input logic [6:0] l, input logic [6:0] r, input int k0, input int k1,
                        input int chg_k, input logic [3:0] c1, input logic [3:0] c2);
      for (int k = k0; k <= k1; k++) begin
         logic [1:0] ean;
         logic [6:0] eseg;
         @(negedge clk);
         ean  = (k >= 2 && k <= 9) ? 2'b01 : (k >= 12) ? 2'b10 : 2'b11;
         eseg = (k >= 2 && k <= 9) ? l : (k >= 12) ? r : 7'h7F;
         checks++;
         assert ({anode_n, seg_n, frame_start} === {ean, eseg, k == 2}) else begin
            failures++;
            $error("FAIL frame k=%0d got an=%b seg=%b fs=%b exp an=%b seg=%b fs=%b",
                   k, anode_n, seg_n, frame_start, ean, eseg, k == 2);
         end
         if (k == chg_k) begin
            switch1 = c1;
            switch2 = c2;
         end
      end
   endtask
   // invariant monitor: no double anode, frozen segments, 20-cycle frame spacing
   logic [6:0] prev_seg;
   logic [1:0] prev_an;
   logic       prev_ok = 1'b0, seen_fs = 1'b0;
   int         gap = 0;
   always @(negedge clk) begin
      checks++;
      assert (anode_n !== 2'b00) else begin
         failures++;
         $error("FAIL anode_both got an=%b exp not 00", anode_n);
      end
      if (!reset) begin
         prev_ok = 1'b0;
         seen_fs = 1'b0;
      end else begin
         if (prev_ok && anode_n == prev_an && anode_n != 2'b11) begin
            checks++;
            assert (seg_n === prev_seg) else begin
               failures++;
               $error("FAIL seg_frozen got seg=%b exp %b", seg_n, prev_seg);
            end
         end
         gap++;
         if (frame_start) begin
            if (seen_fs) begin
               checks++;
               assert (gap == 20) else begin
                  failures++;
                  $error("FAIL fs_spacing got %0d exp 20", gap);
               end
            end
            gap = 0;
            seen_fs = 1'b1;
         end
         prev_ok = 1'b1;
      end
      prev_seg = seg_n;
      prev_an  = anode_n;
   end
   initial begin
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         switch1 = 4'(i * 5 + 3);
         switch2 = 4'(i * 7 + 1);
         check_blank("reset_hold");
      end
      switch1 = 4'h0;
      switch2 = 4'h8;
      repeat (3) begin
         @(negedge clk);
         check_blank("reset_stable");
      end
      @(negedge clk);
      reset = 1'b1;
      frame(D[0], D[8], 1, 19, 99, 4'h0, 4'h8);
      frame(D[0], D[8], 0, 19, 12, 4'h0, 4'h1);
      for (int v = 0; v < 16; v++)
         frame(D[v], D[1], 0, 19, 12, v == 15 ? 4'hA : 4'(v + 1), 4'h1);
      frame(D[10], D[1], 0, 19, 5, 4'hE, 4'h1);
      frame(D[14], D[1], 0, 17, 99, 4'hE, 4'h1);
      #2 reset = 1'b0;
      #1 check_blank("async_reset");
      switch1 = 4'h0;
      repeat (3) begin
         @(negedge clk);
         check_blank("reset_mid");
      end
      @(negedge clk);
      reset = 1'b1;
      frame(D[0], D[1], 1, 19, 99, 4'h0, 4'h1);
      frame(D[0], D[1], 0, 19, 99, 4'h0, 4'h1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
